// File: rtl/bwn_pkg.sv
// Shared definitions for the BWN activation/pooling datapath: default word
// length, the data word type, row-parity FSM encoding and a signed max helper.
package bwn_pkg;

    localparam int D_WL_DEFAULT = 24;
    typedef logic signed [D_WL_DEFAULT-1:0] data_t;

    // Wide signed carrier so one smax serves any word length up to 64 bits;
    // callers sign-extend into it and truncate the result back.
    localparam int SMAX_WL = 64;
    typedef logic signed [SMAX_WL-1:0] smax_t;

    // Row parity of the incoming frame; even rows fill the line buffer,
    // odd rows combine with it and emit pooled values.
    typedef enum logic {
        ROW_EVEN = 1'b0,
        ROW_ODD  = 1'b1
    } pool_row_e;

    // Signed two's-complement maximum; ties return a, which is the same value.
    function automatic smax_t smax(input smax_t a, input smax_t b);
        return (a >= b) ? a : b;
    endfunction

endpackage

// File: rtl/pool_line_buf.sv
// Register-array line buffer: one synchronous write port and one
// combinational read port. Holds the horizontal maxima of an even row.
module pool_line_buf #(
    parameter int DEPTH = 14,
    parameter int WIDTH = 24,
    localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk_i,
    input  logic             we_i,
    input  logic [AW-1:0]    waddr_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic [AW-1:0]    raddr_i,
    output logic [WIDTH-1:0] rdata_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    // Write the addressed entry when enabled.
    // NOTE: no reset on the storage array; every entry is written in an even
    // row before the odd row reads it, so reset would only add wiring.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/pool_max2x2.sv
// Streaming 2x2 / stride-2 max pooling over a row-major IMG_W x IMG_H frame.
// Even rows reduce pixel pairs into a half-width line buffer; odd rows merge
// with it and emit one pooled value per window, one cycle after the last pixel.
module pool_max2x2
    import bwn_pkg::*;
#(
    parameter int D_WL  = D_WL_DEFAULT,   // must not exceed SMAX_WL
    parameter int IMG_W = 28,             // even, >= 2
    parameter int IMG_H = 28              // even, >= 2
) (
    input  logic            CLK,
    input  logic            rst,
    input  logic [D_WL-1:0] in_data,
    input  logic            in_valid,
    output logic [D_WL-1:0] out_data,
    output logic            out_valid,
    output logic            frame_done
);

    localparam int CW    = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int RW    = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam int LB_D  = IMG_W / 2;
    localparam int AW    = (LB_D > 1) ? $clog2(LB_D) : 1;

    localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

    // Signed max at this block's word length via the shared wide helper.
    function automatic logic [D_WL-1:0] wmax(input logic [D_WL-1:0] a,
                                             input logic [D_WL-1:0] b);
        smax_t r;
        r = smax(smax_t'($signed(a)), smax_t'($signed(b)));
        return r[D_WL-1:0];
    endfunction

    pool_row_e       state_q, state_d;
    logic [CW-1:0]   col_q, col_d;
    logic [RW-1:0]   row_q, row_d;
    logic [D_WL-1:0] h_q, h_d;
    logic [D_WL-1:0] out_data_q, out_data_d;
    logic            out_valid_q, out_valid_d;
    logic            frame_done_q, frame_done_d;

    logic            col_last;
    logic            frame_last;
    logic            act_capture;   // even row, even col: load h_reg
    logic            act_lb_write;  // even row, odd col: store pair max
    logic            act_lb_merge;  // odd row, even col: h_reg <- max(lb, pixel)
    logic            act_emit;      // odd row, odd col: produce pooled output

    logic [AW-1:0]   lb_addr;
    logic [D_WL-1:0] lb_rdata;

    assign col_last   = (col_q == COL_LAST);
    assign frame_last = col_last && (row_q == ROW_LAST);
    assign lb_addr    = AW'(col_q >> 1);

    pool_line_buf #(
        .DEPTH (LB_D),
        .WIDTH (D_WL)
    ) u_line_buf (
        .clk_i   (CLK),
        .we_i    (act_lb_write),
        .waddr_i (lb_addr),
        .wdata_i (wmax(h_q, in_data)),
        .raddr_i (lb_addr),
        .rdata_o (lb_rdata)
    );

    // Row-parity state and datapath registers; reset wins over in_valid.
    // NOTE: non-blocking assignments for every register so all of them
    // update from the same pre-edge values, independent of statement order.
    always_ff @(posedge CLK) begin
        if (rst) begin
            state_q      <= ROW_EVEN;
            col_q        <= '0;
            row_q        <= '0;
            h_q          <= '0;
            out_data_q   <= '0;
            out_valid_q  <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            col_q        <= col_d;
            row_q        <= row_d;
            h_q          <= h_d;
            out_data_q   <= out_data_d;
            out_valid_q  <= out_valid_d;
            frame_done_q <= frame_done_d;
        end
    end

    // Next row parity: flip whenever a valid pixel closes a row.
    always_comb begin
        state_d = state_q;
        if (in_valid && col_last) begin
            state_d = (state_q == ROW_EVEN) ? ROW_ODD : ROW_EVEN;
        end
    end

    // Decode the per-pixel action from row parity and column parity.
    // NOTE: every output gets a default before the case so no path leaves
    // one unassigned, which would otherwise infer a latch.
    always_comb begin
        act_capture  = 1'b0;
        act_lb_write = 1'b0;
        act_lb_merge = 1'b0;
        act_emit     = 1'b0;
        if (in_valid) begin
            unique case (state_q)
                ROW_EVEN: begin
                    act_capture  = ~col_q[0];
                    act_lb_write =  col_q[0];
                end
                ROW_ODD: begin
                    act_lb_merge = ~col_q[0];
                    act_emit     =  col_q[0];
                end
                default: ;
            endcase
        end
    end

    // Counters, horizontal max register and output staging.
    always_comb begin
        col_d        = col_q;
        row_d        = row_q;
        h_d          = h_q;
        out_data_d   = out_data_q;
        out_valid_d  = 1'b0;
        frame_done_d = 1'b0;

        if (in_valid) begin
            col_d = col_last ? '0 : col_q + CW'(1);
            if (col_last) begin
                row_d = (row_q == ROW_LAST) ? '0 : row_q + RW'(1);
            end
        end

        if (act_capture) begin
            h_d = in_data;
        end
        if (act_lb_merge) begin
            h_d = wmax(lb_rdata, in_data);
        end
        if (act_emit) begin
            out_data_d   = wmax(h_q, in_data);
            out_valid_d  = 1'b1;
            frame_done_d = frame_last;
        end
    end

    assign out_data   = out_data_q;
    assign out_valid  = out_valid_q;
    assign frame_done = frame_done_q;

endmodule
